// File: rtl/tube_scan_ctrl.sv
// Memory-mapped controller for two 4-digit multiplexed 7-seg banks plus one static digit.
// Optional leading-zero blanking over the 8-digit value is enabled with `define TUBE_LZB_EN.
module tube_scan_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic        wr_en,
  input  logic        wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        rd_addr,
  output logic [31:0] rd_data,
  output logic [7:0]  digital_tube0,
  output logic [3:0]  digital_tube_sel0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

  logic [31:0]     data;
  logic [8:0]      ctrl;
  logic [TW-1:0]   tick;
  logic [1:0]      idx, idx_nxt;
  logic            wrap;
  logic [1:0][3:0] nib;
  logic [1:0]      blank;
  logic [1:0][7:0] seg_nxt;

  function automatic logic [7:0] seg(input logic [3:0] h);
    case (h)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
    endcase
  endfunction

  assign wrap    = (tick == TICK_LAST);
  assign idx_nxt = wrap ? idx + 2'd1 : idx;
  assign rd_data = rd_addr ? {23'd0, ctrl} : data;

  // Pins are registered from the post-advance index but the pre-write DATA/CTRL.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [4:0] base;
    assign base   = 5'(b * 16) | {1'b0, idx_nxt, 2'b00};
    assign nib[b] = data[base +: 4];
`ifdef TUBE_LZB_EN
    assign blank[b] = (base != 5'd0) && ((data >> base) == 32'd0);
`else
    assign blank[b] = 1'b0;
`endif
    assign seg_nxt[b] = (!ctrl[0] || blank[b]) ? 8'hFF : seg(nib[b]);
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      data              <= '0;
      ctrl              <= 9'h001;
      tick              <= '0;
      idx               <= '0;
      digital_tube0     <= 8'hFF;
      digital_tube_sel0 <= 4'b0001;
      digital_tube1     <= 8'hFF;
      digital_tube_sel1 <= 4'b0001;
      digital_tube2     <= 8'hFF;
      digital_tube_sel2 <= 1'b0;
    end else begin
      tick <= wrap ? '0 : tick + 1'b1;
      idx  <= idx_nxt;
      if (wr_en) begin
        if (wr_addr) begin
          ctrl <= wr_data[8:0];
        end else begin
          for (int b = 0; b < 4; b++)
            if (wr_be[b]) data[8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      digital_tube0     <= seg_nxt[0];
      digital_tube_sel0 <= 4'b0001 << idx_nxt;
      digital_tube1     <= seg_nxt[1];
      digital_tube_sel1 <= 4'b0001 << idx_nxt;
      digital_tube2     <= ctrl[8] ? seg(ctrl[7:4]) : 8'hFF;
      digital_tube_sel2 <= ctrl[8];
    end
  end
endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Scoreboard bench for tube_scan_ctrl: a cycle-count model pushes expected pins each edge,
// a negedge monitor pops and compares. Define TUBE_LZB_EN to check leading-zero blanking.
module tb_tube_scan_ctrl;
  localparam int DIV = 4;

  logic        clk_in = 1'b0, sys_rstn = 1'b0;
  logic        wr_en = 1'b0, wr_addr = 1'b0, rd_addr = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] rd_data;
  logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
  logic [3:0]  digital_tube_sel0, digital_tube_sel1;
  logic        digital_tube_sel2;

  tube_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk_in(clk_in), .sys_rstn(sys_rstn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_data),
    .digital_tube0(digital_tube0), .digital_tube_sel0(digital_tube_sel0),
    .digital_tube1(digital_tube1), .digital_tube_sel1(digital_tube_sel1),
    .digital_tube2(digital_tube2), .digital_tube_sel2(digital_tube_sel2)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] t0; logic [3:0] s0;
    logic [7:0] t1; logic [3:0] s1;
    logic [7:0] t2; logic       s2;
  } pins_t;

  localparam pins_t RST_PINS = '{t0: 8'hFF, s0: 4'b0001, t1: 8'hFF, s1: 4'b0001, t2: 8'hFF, s2: 1'b0};

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  pins_t       q[$];
  int          errors = 0, checks = 0;
  logic [31:0] m_data = '0;
  logic [8:0]  m_ctrl = 9'h001;
  int          edges = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Global digit k: bank0 idx -> k=idx, bank1 idx -> k=4+idx.
  function automatic logic [7:0] digit(input int k);
    logic [31:0] upper;
    upper = m_data >> (4 * k);
    if (!m_ctrl[0]) return 8'hFF;
`ifdef TUBE_LZB_EN
    if (k > 0 && upper == 0) return 8'hFF;
`endif
    return seg_tab[upper[3:0]];
  endfunction

  function automatic pins_t expect_pins(input int idx);
    pins_t p;
    p.t0 = digit(idx);
    p.s0 = 4'(1 << idx);
    p.t1 = digit(4 + idx);
    p.s1 = 4'(1 << idx);
    p.s2 = m_ctrl[8];
    p.t2 = m_ctrl[8] ? seg_tab[m_ctrl[7:4]] : 8'hFF;
    return p;
  endfunction

  // Slot index after edge n since reset is simply (n / DIV) mod 4.
  always @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      m_data = '0;
      m_ctrl = 9'h001;
      edges  = 0;
      q.delete();
    end else begin
      edges++;
      q.push_back(expect_pins((edges / DIV) % 4));
      if (wr_en) begin
        if (wr_addr) m_ctrl = wr_data[8:0];
        else for (int b = 0; b < 4; b++) if (wr_be[b]) m_data[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always @(negedge clk_in) begin
    pins_t a, e;
    a = '{t0: digital_tube0, s0: digital_tube_sel0, t1: digital_tube1, s1: digital_tube_sel1,
          t2: digital_tube2, s2: digital_tube_sel2};
    if (!sys_rstn || q.size() == 0) e = RST_PINS;
    else e = q.pop_front();
    chk("pins{t0,s0,t1,s1,t2,s2}", 64'(a), 64'(e));
    chk("rd_data", 64'(rd_data), 64'(rd_addr ? {23'd0, m_ctrl} : m_data));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic wr(input logic a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    cyc(3);
    sys_rstn = 1'b1;
    cyc(20);                                   // idle scan of DATA=0
    wr(1'b0, 32'h89AB_CDEF, 4'hF);
    rd_addr = 1'b0;
    cyc(18);
    chk("rd_data_89abcdef", 64'(rd_data), 64'h89AB_CDEF);
    wr(1'b0, 32'h0055_0000, 4'b0100);
    cyc(17);
    chk("rd_data_8955cdef", 64'(rd_data), 64'h8955_CDEF);
    wr(1'b1, 32'h0000_0170, 4'h0);
    rd_addr = 1'b1;
    cyc(6);
    wr(1'b1, 32'hFFFF_FE00, 4'hF);             // EN off, upper bits ignored
    cyc(18);
    wr(1'b1, 32'h0000_0001, 4'h0);
    rd_addr = 1'b0;
    wr(1'b0, 32'h0000_0120, 4'hF);
    cyc(18);

    for (int i = 0; i < 400; i++) begin
      rd_addr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        logic        a;
        logic [31:0] d;
        a = ($urandom_range(0, 3) == 0);
        d = $urandom >> $urandom_range(0, 31);
        if (a && $urandom_range(0, 3) != 0) d[0] = 1'b1;
        wr(a, d, 4'($urandom));
      end else begin
        cyc();
      end
    end

    // Reset in slot 2 with a write on the bus.
    for (int i = 0; i < 40 && ((edges / DIV) % 4) != 2; i++) cyc();
    wr_en = 1'b1; wr_addr = 1'b0; wr_data = 32'h1234_5678; wr_be = 4'hF;
    sys_rstn = 1'b0;
    #1;
    chk("async_reset_pins", 64'({digital_tube0, digital_tube_sel0, digital_tube1, digital_tube_sel1,
        digital_tube2, digital_tube_sel2}), 64'(RST_PINS));
    cyc(2);
    wr_en = 1'b0;
    sys_rstn = 1'b1;
    rd_addr = 1'b0;
    #1;
    chk("data_after_reset", 64'(rd_data), 64'd0);
    cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
